// File: rtl/aemb2_sram_arb.sv
// Two-master arbiter sharing one single-port, registered-read SRAM between
// the instruction and data buses; one transaction per IDLE -> ACC -> ACK pass.
//
// state | meaning
// IDLE  | waiting for a strobe; grant chosen and request latched on exit
// ACC   | RAM enabled for one cycle with the latched request
// ACK   | RAM read data valid; granted master acked if still strobing
module aemb2_sram_arb #(
   parameter int AW = 14
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_i,
   input  logic          iwb_stb_o,
   input  logic [AW-1:2] iwb_adr_o,
   output logic [31:0]   iwb_dat_i,
   output logic          iwb_ack_i,
   input  logic          dwb_stb_o,
   input  logic          dwb_wre_o,
   input  logic [3:0]    dwb_sel_o,
   input  logic [AW-1:2] dwb_adr_o,
   input  logic [31:0]   dwb_dat_o,
   output logic [31:0]   dwb_dat_i,
   output logic          dwb_ack_i,
   output logic [AW-1:2] ram_adr_o,
   output logic [31:0]   ram_dat_o,
   input  logic [31:0]   ram_dat_i,
   output logic          ram_wre_o,
   output logic [3:0]    ram_ena_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_ACK} state_t;

   state_t          r_state;
   logic            r_gnt;
   logic            r_last_gnt;
   logic            r_iack;
   logic            r_dack;
   logic [3:0]      r_ena;
   logic            r_wre;
   logic [AW-1:2]   r_adr;
   logic [31:0]     r_dat;
   logic            w_gnt_next;

   // Under contention the master not served last time wins.
   assign w_gnt_next = (iwb_stb_o && dwb_stb_o) ? ~r_last_gnt : dwb_stb_o;

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         r_state    <= S_IDLE;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b0;
         r_iack     <= 1'b0;
         r_dack     <= 1'b0;
         r_ena      <= 4'h0;
         r_wre      <= 1'b0;
         r_adr      <= '0;
         r_dat      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_iack <= 1'b0;
               r_dack <= 1'b0;
               if (iwb_stb_o || dwb_stb_o) begin
                  r_state    <= S_ACC;
                  r_gnt      <= w_gnt_next;
                  r_last_gnt <= w_gnt_next;
                  r_ena      <= w_gnt_next ? dwb_sel_o : 4'hF;
                  r_wre      <= w_gnt_next & dwb_wre_o;
                  r_adr      <= w_gnt_next ? dwb_adr_o : iwb_adr_o;
                  r_dat      <= dwb_dat_o;
               end
            end
            S_ACC: begin
               // Access completes regardless; the ack needs the strobe still up.
               r_state <= S_ACK;
               r_ena   <= 4'h0;
               r_wre   <= 1'b0;
               r_iack  <= ~r_gnt & iwb_stb_o;
               r_dack  <= r_gnt & dwb_stb_o;
            end
            S_ACK: begin
               r_state <= S_IDLE;
               r_iack  <= 1'b0;
               r_dack  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_iack  <= 1'b0;
               r_dack  <= 1'b0;
               r_ena   <= 4'h0;
               r_wre   <= 1'b0;
            end
         endcase
      end
   end

   assign ram_adr_o = r_adr;
   assign ram_dat_o = r_dat;
   assign ram_ena_o = r_ena;
   assign ram_wre_o = r_wre;
   assign iwb_ack_i = r_iack;
   assign dwb_ack_i = r_dack;
   assign iwb_dat_i = ram_dat_i;
   assign dwb_dat_i = ram_dat_i;

endmodule

// File: tb/tb_aemb2_sram_arb.sv
// Scoreboard bench for aemb2_sram_arb with a byte-lane, registered-read RAM
// model; expected read data queued per master and popped on each ack.
module tb_aemb2_sram_arb;
   localparam int AW = 14;

   logic          sys_clk_i = 1'b0;
   logic          sys_rst_i = 1'b1;
   logic          iwb_stb_o = 1'b0;
   logic [AW-1:2] iwb_adr_o = '0;
   logic [31:0]   iwb_dat_i;
   logic          iwb_ack_i;
   logic          dwb_stb_o = 1'b0;
   logic          dwb_wre_o = 1'b0;
   logic [3:0]    dwb_sel_o = 4'h0;
   logic [AW-1:2] dwb_adr_o = '0;
   logic [31:0]   dwb_dat_o = '0;
   logic [31:0]   dwb_dat_i;
   logic          dwb_ack_i;
   logic [AW-1:2] ram_adr_o;
   logic [31:0]   ram_dat_o;
   logic [31:0]   ram_dat_i;
   logic          ram_wre_o;
   logic [3:0]    ram_ena_o;

   aemb2_sram_arb #(.AW(AW)) dut (
      .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
      .iwb_stb_o(iwb_stb_o), .iwb_adr_o(iwb_adr_o), .iwb_dat_i(iwb_dat_i), .iwb_ack_i(iwb_ack_i),
      .dwb_stb_o(dwb_stb_o), .dwb_wre_o(dwb_wre_o), .dwb_sel_o(dwb_sel_o), .dwb_adr_o(dwb_adr_o),
      .dwb_dat_o(dwb_dat_o), .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
      .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i),
      .ram_wre_o(ram_wre_o), .ram_ena_o(ram_ena_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   logic [31:0] mem [0:4095];
   logic [31:0] ram_q = '0;
   assign ram_dat_i = ram_q;

   always @(posedge sys_clk_i) begin
      if (|ram_ena_o) begin
         ram_q <= mem[ram_adr_o];
         for (int b = 0; b < 4; b++)
            if (ram_wre_o && ram_ena_o[b]) mem[ram_adr_o][b*8 +: 8] <= ram_dat_o[b*8 +: 8];
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // {check_data, expected_data}
   logic [32:0] iq [$];
   logic [32:0] dq [$];
   bit          ack_order [$];
   int          n_iack = 0, n_dack = 0, n_ena = 0, n_overlap = 0;
   logic [3:0]  last_ena = 4'h0;

   always @(negedge sys_clk_i) begin
      logic [32:0] e;
      if (iwb_ack_i && dwb_ack_i) n_overlap++;
      if (|ram_ena_o) begin n_ena++; last_ena = ram_ena_o; end
      if (iwb_ack_i) begin
         n_iack++;
         ack_order.push_back(1'b0);
         if (iq.size() == 0) chk("iq_underflow", 32'd1, 32'd0);
         else begin
            e = iq.pop_front();
            if (e[32]) chk("iwb_dat", iwb_dat_i, e[31:0]);
         end
      end
      if (dwb_ack_i) begin
         n_dack++;
         ack_order.push_back(1'b1);
         if (dq.size() == 0) chk("dq_underflow", 32'd1, 32'd0);
         else begin
            e = dq.pop_front();
            if (e[32]) chk("dwb_dat", dwb_dat_i, e[31:0]);
         end
      end
   end

   task automatic i_req(input logic [AW-1:2] adr, input logic [31:0] exp, output int lat);
      int n = 0;
      iq.push_back({1'b1, exp});
      iwb_adr_o = adr;
      iwb_stb_o = 1'b1;
      do begin @(negedge sys_clk_i); n++; end while (!iwb_ack_i && n < 20);
      if (!iwb_ack_i) chk("iwb_timeout", 32'd0, 32'd1);
      lat = n - 1;
      @(posedge sys_clk_i); #1;
      iwb_stb_o = 1'b0;
   endtask

   task automatic d_req(input logic wre, input logic [3:0] sel, input logic [AW-1:2] adr,
                        input logic [31:0] dat, input logic [31:0] exp);
      int n = 0;
      dq.push_back({~wre, exp});
      dwb_wre_o = wre; dwb_sel_o = sel; dwb_adr_o = adr; dwb_dat_o = dat;
      dwb_stb_o = 1'b1;
      do begin @(negedge sys_clk_i); n++; end while (!dwb_ack_i && n < 20);
      if (!dwb_ack_i) chk("dwb_timeout", 32'd0, 32'd1);
      @(posedge sys_clk_i); #1;
      dwb_stb_o = 1'b0;
      dwb_wre_o = 1'b0;
   endtask

   task automatic contend(input int n);
      int lat;
      fork
         for (int k = 0; k < n; k++) i_req(12'h040, 32'h1111_0040, lat);
         for (int k = 0; k < n; k++) d_req(1'b0, 4'hF, 12'h080, 32'h0, 32'h2222_0080);
      join
   endtask

   initial begin
      int lat, a0, b0, e0;
      for (int k = 0; k < 4096; k++) mem[k] = 32'h0;
      mem[12'h010] = 32'hDEAD_BEEF;
      mem[12'h020] = 32'hAAAA_AAAA;
      mem[12'h040] = 32'h1111_0040;
      mem[12'h080] = 32'h2222_0080;
      mem[12'h100] = 32'h5555_5555;

      repeat (3) @(posedge sys_clk_i);
      #1 sys_rst_i = 1'b0;
      @(negedge sys_clk_i);
      chk("rst_ena", {28'h0, ram_ena_o}, 32'h0);
      chk("rst_wre", {31'h0, ram_wre_o}, 32'h0);
      chk("rst_acks", {30'h0, iwb_ack_i, dwb_ack_i}, 32'h0);
      @(posedge sys_clk_i); #1;

      // Sustained contention straight out of reset: D, I, D, I
      ack_order.delete();
      contend(2);
      chk("order_len", ack_order.size(), 32'd4);
      if (ack_order.size() == 4)
         chk("order", {28'h0, ack_order[0], ack_order[1], ack_order[2], ack_order[3]}, 32'b1010);
      repeat (3) @(posedge sys_clk_i); #1;

      // Uncontended instruction read
      e0 = n_ena;
      i_req(12'h010, 32'hDEAD_BEEF, lat);
      chk("i_latency", lat, 32'd2);
      chk("i_ena_cycles", n_ena - e0, 32'd1);
      chk("i_ena_val", {28'h0, last_ena}, 32'hF);

      // Partial write then read back
      d_req(1'b1, 4'b0011, 12'h020, 32'h1234_5678, 32'h0);
      chk("wr_mem", mem[12'h020], 32'hAAAA_5678);
      d_req(1'b0, 4'hF, 12'h020, 32'h0, 32'hAAAA_5678);

      // Strobe withdrawn during ACC on a write: RAM updates, no ack
      b0 = n_dack;
      dwb_wre_o = 1'b1; dwb_sel_o = 4'hF; dwb_adr_o = 12'h030; dwb_dat_o = 32'hCAFE_F00D;
      dwb_stb_o = 1'b1;
      @(posedge sys_clk_i); #1;
      dwb_stb_o = 1'b0; dwb_wre_o = 1'b0;
      @(posedge sys_clk_i); #1;
      @(posedge sys_clk_i); #1;
      i_req(12'h010, 32'hDEAD_BEEF, lat);
      chk("drop_idle_lat", lat, 32'd2);
      chk("drop_mem", mem[12'h030], 32'hCAFE_F00D);
      chk("drop_noack", n_dack - b0, 32'd0);

      // Write with no lanes selected
      b0 = n_dack;
      d_req(1'b1, 4'h0, 12'h100, 32'h0123_4567, 32'h0);
      chk("sel0_mem", mem[12'h100], 32'h5555_5555);
      chk("sel0_ack", n_dack - b0, 32'd1);

      // Reset during a data ACC: aborted, and last_gnt cleared
      a0 = n_iack; b0 = n_dack;
      dwb_wre_o = 1'b0; dwb_sel_o = 4'hF; dwb_adr_o = 12'h080;
      dwb_stb_o = 1'b1;
      @(posedge sys_clk_i); #1;
      sys_rst_i = 1'b1; dwb_stb_o = 1'b0;
      @(posedge sys_clk_i); #1;
      sys_rst_i = 1'b0;
      @(negedge sys_clk_i);
      chk("rst_acc_ena", {28'h0, ram_ena_o}, 32'h0);
      repeat (4) @(negedge sys_clk_i);
      chk("rst_acc_noack", (n_iack - a0) + (n_dack - b0), 32'd0);
      @(posedge sys_clk_i); #1;
      ack_order.delete();
      contend(1);
      chk("rst_order_len", ack_order.size(), 32'd2);
      if (ack_order.size() == 2)
         chk("rst_order", {30'h0, ack_order[0], ack_order[1]}, 32'b10);

      chk("ack_overlap", n_overlap, 32'd0);
      chk("q_drained", iq.size() + dq.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
